arb_rr_encoder: RTL and testbench
=================================

ARB_RR_ENCODER -- requirements
Module: arb_rr_encoder

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesters, any integer >= 2.
REQ-002 SHALL have parameter ROUND_ROBIN, default 0: 1 = round-robin priority, 0 = fixed priority.
REQ-003 SHALL have parameter LSB_HIGH_PRIORITY, default 0: 1 = port 0 highest in fixed mode and in round-robin tie-break; 0 = port PORTS-1 highest.
REQ-004 SHALL have parameter BLOCK, default 0: 1 = grant held across cycles; 0 = re-arbitrate every cycle.
REQ-005 SHALL have parameter BLOCK_ACK, default 0: only when BLOCK=1; 1 = hold until acknowledge; 0 = hold while request stays high.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, all state rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port request, input, PORTS bits: one request per port.
REQ-009 SHALL have port acknowledge, input, PORTS bits: release pulse, used only when BLOCK=1 and BLOCK_ACK=1.
REQ-010 SHALL have port grant, output, PORTS bits: registered one-hot grant.
REQ-011 SHALL have port grant_valid, output, 1 bit: registered, high when grant is nonzero.
REQ-012 SHALL have port grant_encoded, output, $clog2(PORTS) bits: registered binary index of the granted port.

Function
REQ-013 SHALL register all outputs; a request seen at edge N SHALL appear as a grant after edge N; latency is 1 cycle.
REQ-014 SHALL, in fixed mode, grant the highest-priority asserted request each arbitration cycle.
REQ-015 SHALL, in round-robin mode, keep a PORTS-bit mask register; after granting index i the mask SHALL hold ones at bits > i (LSB_HIGH_PRIORITY=1) or bits < i (LSB_HIGH_PRIORITY=0).
REQ-016 SHALL, in round-robin mode, grant from request & mask when that is nonzero, else from unmasked request, using the priority rule of REQ-003.
REQ-017 SHALL update the mask only on a cycle where a new grant is issued, and SHALL leave it unchanged on idle cycles.
REQ-018 SHALL keep a two-state FSM when BLOCK=1: IDLE -> LOCKED on issuing a grant.
REQ-019 SHALL leave LOCKED for IDLE when request[granted] is low (BLOCK_ACK=0) or acknowledge[granted] is high (BLOCK_ACK=1).
REQ-020 SHALL hold grant, grant_valid and grant_encoded stable while LOCKED.
REQ-021 SHALL re-arbitrate in the same cycle a lock releases, so back-to-back grants to different ports need no idle cycle.
REQ-022 SHALL ignore acknowledge bits for non-granted ports and SHALL ignore acknowledge entirely when BLOCK_ACK=0.
REQ-023 SHALL, with BLOCK=0, re-arbitrate every cycle, so a continuously requesting port may keep its grant in fixed mode.
REQ-024 SHALL drive grant=0, grant_valid=0 and grant_encoded=0 when no request is asserted in an arbitration cycle.
REQ-025 SHALL, in LOCKED with BLOCK_ACK=1, keep the grant even if request[granted] drops before acknowledge.
REQ-026 SHALL keep grant one-hot or zero at all times, with grant_encoded consistent with grant whenever grant_valid=1.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force grant=0, grant_valid=0, grant_encoded=0, mask=0 and FSM=IDLE.
REQ-028 SHALL, on reset mid-lock, drop the grant immediately; the first edge after deassertion SHALL arbitrate as from power-up.

Structure
REQ-029 SHALL implement selection with two instances of the existing priority_encoder module (masked and unmasked), each with WIDTH=PORTS and LSB_HIGH_PRIORITY passed through.
REQ-030 SHALL place shared constants (FSM state encodings IDLE/LOCKED) in the project common package; no other package content is required.
REQ-031 SHALL keep the mask, FSM and output registers inside arb_rr_encoder, with no other sub-modules.

Verification (PORTS=4)
REQ-032 SHALL test fixed mode, LSB_HIGH_PRIORITY=1, request=4'b1010 -> grant=4'b0010, grant_encoded=1, one cycle later.
REQ-033 SHALL test round-robin, LSB_HIGH_PRIORITY=1, BLOCK=0, request held at 4'b1111 -> grant_encoded sequence 0,1,2,3,0.
REQ-034 SHALL test BLOCK=1, BLOCK_ACK=0: grant port 2, then assert request[0] -> grant stays 4'b0100 until request[2] drops, then 4'b0001 on the next edge.
REQ-035 SHALL test BLOCK=1, BLOCK_ACK=1: grant port 1, drop request[1] -> grant held; acknowledge=4'b0010 -> released; acknowledge=4'b1000 while locked -> ignored.
REQ-036 SHALL test reset: pulse rst_n low while locked on port 3 -> grant=0, grant_valid=0 at once; with round-robin and request=4'b1001 after release -> grant_encoded=0 first (mask cleared).
REQ-037 SHALL test request=0 for several cycles -> grant_valid=0, grant_encoded=0, and the round-robin mask unchanged.

Source files
------------

// File: rtl/arb_rr_encoder_pkg.sv
// Shared definitions for the request arbiter/encoder.
package arb_rr_encoder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_rr_encoder_priority_encoder.sv
// Combinational priority encoder: one-hot and binary index of the winning bit.
module priority_encoder #(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 0
) (
  input  logic [WIDTH-1:0]         bits,
  output logic                     valid,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic [WIDTH-1:0]         onehot
);

  localparam int IDX_W = $clog2(WIDTH);

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (bits[i]) begin
          valid     = 1'b1;
          index     = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bits[i]) begin
          valid     = 1'b1;
          index     = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arb_rr_encoder.sv
// Registered arbiter with fixed or round-robin priority and optional grant locking.
//   state  | meaning
//   IDLE   | no grant held; arbitrate this cycle
//   LOCKED | grant held until request drops (or acknowledge, in ack mode)
module arb_rr_encoder
  import arb_rr_encoder_pkg::*;
#(
  parameter int PORTS             = 4,
  parameter int ROUND_ROBIN       = 0,
  parameter int LSB_HIGH_PRIORITY = 0,
  parameter int BLOCK             = 0,
  parameter int BLOCK_ACK         = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);

  localparam int IDX_W = $clog2(PORTS);

  arb_state_t       state, state_next;
  logic [PORTS-1:0] mask, mask_next, masked_request;
  logic [PORTS-1:0] m_onehot, u_onehot, sel_onehot;
  logic             m_valid, u_valid, sel_valid;
  logic [IDX_W-1:0] m_index, u_index, sel_index;
  logic             release_lock, arbitrate;

  assign masked_request = request & mask;

  priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_masked (
    .bits   (masked_request),
    .valid  (m_valid),
    .index  (m_index),
    .onehot (m_onehot)
  );

  priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_unmasked (
    .bits   (request),
    .valid  (u_valid),
    .index  (u_index),
    .onehot (u_onehot)
  );

  always_comb begin
    sel_valid  = u_valid;
    sel_index  = u_index;
    sel_onehot = u_onehot;
    if (ROUND_ROBIN != 0 && m_valid) begin
      sel_valid  = m_valid;
      sel_index  = m_index;
      sel_onehot = m_onehot;
    end
  end

  // Ports after the winner in priority order become preferred next time.
  always_comb begin
    mask_next = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (LSB_HIGH_PRIORITY != 0) mask_next[j] = (j > int'(sel_index));
      else                        mask_next[j] = (j < int'(sel_index));
    end
  end

  assign release_lock = (BLOCK_ACK != 0) ? |(acknowledge & grant) : ~|(request & grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A release re-arbitrates in the same cycle so handover needs no idle gap.
  always_comb begin
    state_next = state;
    arbitrate  = 1'b1;
    if (BLOCK != 0) begin
      case (state)
        IDLE:    arbitrate = 1'b1;
        LOCKED:  arbitrate = release_lock;
        default: arbitrate = 1'b1;
      endcase
      if (arbitrate) state_next = sel_valid ? LOCKED : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '0;
    end else if (arbitrate) begin
      grant         <= sel_onehot;
      grant_valid   <= sel_valid;
      grant_encoded <= sel_index;
      if (ROUND_ROBIN != 0 && sel_valid) mask <= mask_next;
    end
  end

endmodule

// File: tb/tb_arb_rr_encoder.sv
// Directed bench covering fixed, round-robin, locked, acknowledged and reset behaviour.
module tb_arb_rr_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0] req_fix, req_rr, req_blk, req_ack, req_rst;
  logic [3:0] ack_ack, ack_none;
  logic [3:0] g_fix, g_rr, g_blk, g_ack, g_rst;
  logic       v_fix, v_rr, v_blk, v_ack, v_rst;
  logic [1:0] e_fix, e_rr, e_blk, e_ack, e_rst;

  arb_rr_encoder #(.PORTS(4), .ROUND_ROBIN(0), .LSB_HIGH_PRIORITY(1), .BLOCK(0), .BLOCK_ACK(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .request(req_fix), .acknowledge(ack_none),
    .grant(g_fix), .grant_valid(v_fix), .grant_encoded(e_fix));

  arb_rr_encoder #(.PORTS(4), .ROUND_ROBIN(1), .LSB_HIGH_PRIORITY(1), .BLOCK(0), .BLOCK_ACK(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .request(req_rr), .acknowledge(ack_none),
    .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr));

  arb_rr_encoder #(.PORTS(4), .ROUND_ROBIN(0), .LSB_HIGH_PRIORITY(1), .BLOCK(1), .BLOCK_ACK(0)) u_blk (
    .clk(clk), .rst_n(rst_n), .request(req_blk), .acknowledge(ack_none),
    .grant(g_blk), .grant_valid(v_blk), .grant_encoded(e_blk));

  arb_rr_encoder #(.PORTS(4), .ROUND_ROBIN(0), .LSB_HIGH_PRIORITY(1), .BLOCK(1), .BLOCK_ACK(1)) u_ack (
    .clk(clk), .rst_n(rst_n), .request(req_ack), .acknowledge(ack_ack),
    .grant(g_ack), .grant_valid(v_ack), .grant_encoded(e_ack));

  arb_rr_encoder #(.PORTS(4), .ROUND_ROBIN(1), .LSB_HIGH_PRIORITY(1), .BLOCK(1), .BLOCK_ACK(0)) u_rst (
    .clk(clk), .rst_n(rst_n), .request(req_rst), .acknowledge(ack_none),
    .grant(g_rst), .grant_valid(v_rst), .grant_encoded(e_rst));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_fix = '0; req_rr = '0; req_blk = '0; req_ack = '0; req_rst = '0;
    ack_ack = '0; ack_none = '0;
    #12;
    checks++;
    if ({g_fix, v_fix, e_fix} !== 7'd0) begin
      failures++; $display("FAIL reset_fix got=%b expected=0", {g_fix, v_fix, e_fix});
    end
    checks++;
    if ({g_rr, v_rr, e_rr} !== 7'd0) begin
      failures++; $display("FAIL reset_rr got=%b expected=0", {g_rr, v_rr, e_rr});
    end
    checks++;
    if ({g_blk, v_blk, e_blk, g_ack, v_ack, e_ack, g_rst, v_rst, e_rst} !== 21'd0) begin
      failures++; $display("FAIL reset_block got=%b expected=0",
                           {g_blk, v_blk, e_blk, g_ack, v_ack, e_ack, g_rst, v_rst, e_rst});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed();
    logic [3:0] reqs  [5] = '{4'b1010, 4'b1000, 4'b0110, 4'b1111, 4'b0000};
    logic [3:0] exp_g [5] = '{4'b0010, 4'b1000, 4'b0010, 4'b0001, 4'b0000};
    logic [1:0] exp_e [5] = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd0};
    logic       exp_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    req_fix = 4'b1010;
    #2;
    checks++;
    if (g_fix !== 4'b0000) begin
      failures++; $display("FAIL fixed_latency grant=%b expected=0000", g_fix);
    end
    for (int i = 0; i < 5; i++) begin
      req_fix = reqs[i];
      tick();
      checks++;
      if ({g_fix, v_fix, e_fix} !== {exp_g[i], exp_v[i], exp_e[i]}) begin
        failures++;
        $display("FAIL fixed[%0d] grant=%b valid=%b enc=%0d expected grant=%b valid=%b enc=%0d",
                 i, g_fix, v_fix, e_fix, exp_g[i], exp_v[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] hot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req_rr = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({g_rr, v_rr, e_rr} !== {hot[i], 1'b1, seq[i]}) begin
        failures++;
        $display("FAIL rr_seq[%0d] grant=%b valid=%b enc=%0d expected grant=%b valid=1 enc=%0d",
                 i, g_rr, v_rr, e_rr, hot[i], seq[i]);
      end
    end
  endtask

  task automatic test_idle();
    req_rr = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({g_rr, v_rr, e_rr} !== 7'd0) begin
        failures++;
        $display("FAIL idle[%0d] grant=%b valid=%b enc=%0d expected all zero", i, g_rr, v_rr, e_rr);
      end
    end
    // Mask must still prefer ports above 0 after the idle stretch.
    req_rr = 4'b1111;
    tick();
    checks++;
    if ({g_rr, e_rr} !== {4'b0010, 2'd1}) begin
      failures++; $display("FAIL idle_mask_kept grant=%b enc=%0d expected grant=0010 enc=1", g_rr, e_rr);
    end
    req_rr = 4'b0000;
    tick();
  endtask

  task automatic test_block();
    req_blk = 4'b0100;
    tick();
    checks++;
    if ({g_blk, v_blk, e_blk} !== {4'b0100, 1'b1, 2'd2}) begin
      failures++; $display("FAIL block_first grant=%b enc=%0d expected grant=0100 enc=2", g_blk, e_blk);
    end
    req_blk = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({g_blk, v_blk, e_blk} !== {4'b0100, 1'b1, 2'd2}) begin
        failures++; $display("FAIL block_hold[%0d] grant=%b enc=%0d expected grant=0100 enc=2", i, g_blk, e_blk);
      end
    end
    req_blk = 4'b0001;
    tick();
    checks++;
    if ({g_blk, v_blk, e_blk} !== {4'b0001, 1'b1, 2'd0}) begin
      failures++; $display("FAIL block_handover grant=%b enc=%0d expected grant=0001 enc=0", g_blk, e_blk);
    end
    req_blk = 4'b0000;
    tick();
    checks++;
    if ({g_blk, v_blk, e_blk} !== 7'd0) begin
      failures++; $display("FAIL block_release grant=%b valid=%b expected grant=0000 valid=0", g_blk, v_blk);
    end
  endtask

  task automatic test_block_ack();
    req_ack = 4'b0010;
    tick();
    checks++;
    if ({g_ack, v_ack, e_ack} !== {4'b0010, 1'b1, 2'd1}) begin
      failures++; $display("FAIL ack_first grant=%b enc=%0d expected grant=0010 enc=1", g_ack, e_ack);
    end
    req_ack = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({g_ack, v_ack, e_ack} !== {4'b0010, 1'b1, 2'd1}) begin
        failures++; $display("FAIL ack_hold_nreq[%0d] grant=%b expected grant=0010", i, g_ack);
      end
    end
    ack_ack = 4'b1000;
    tick();
    checks++;
    if ({g_ack, v_ack, e_ack} !== {4'b0010, 1'b1, 2'd1}) begin
      failures++; $display("FAIL ack_foreign grant=%b expected grant=0010", g_ack);
    end
    ack_ack = 4'b0010;
    tick();
    checks++;
    if ({g_ack, v_ack, e_ack} !== 7'd0) begin
      failures++; $display("FAIL ack_release grant=%b valid=%b expected grant=0000 valid=0", g_ack, v_ack);
    end
    ack_ack = 4'b0000;
  endtask

  task automatic test_back_to_back();
    req_ack = 4'b0110;
    tick();
    checks++;
    if ({g_ack, e_ack} !== {4'b0010, 2'd1}) begin
      failures++; $display("FAIL b2b_first grant=%b enc=%0d expected grant=0010 enc=1", g_ack, e_ack);
    end
    req_ack = 4'b0100;
    ack_ack = 4'b0010;
    tick();
    checks++;
    if ({g_ack, v_ack, e_ack} !== {4'b0100, 1'b1, 2'd2}) begin
      failures++; $display("FAIL b2b_second grant=%b enc=%0d expected grant=0100 enc=2", g_ack, e_ack);
    end
    req_ack = 4'b0000;
    ack_ack = 4'b0000;
    tick();
    checks++;
    if ({g_ack, e_ack} !== {4'b0100, 2'd2}) begin
      failures++; $display("FAIL b2b_hold grant=%b expected grant=0100", g_ack);
    end
    ack_ack = 4'b0100;
    tick();
    checks++;
    if ({g_ack, v_ack} !== 5'd0) begin
      failures++; $display("FAIL b2b_release grant=%b valid=%b expected grant=0000 valid=0", g_ack, v_ack);
    end
    ack_ack = 4'b0000;
  endtask

  task automatic test_reset_mid_lock();
    req_rst = 4'b1000;
    tick();
    checks++;
    if ({g_rst, v_rst, e_rst} !== {4'b1000, 1'b1, 2'd3}) begin
      failures++; $display("FAIL rst_lock grant=%b enc=%0d expected grant=1000 enc=3", g_rst, e_rst);
    end
    tick();
    checks++;
    if ({g_rst, e_rst} !== {4'b1000, 2'd3}) begin
      failures++; $display("FAIL rst_lock_hold grant=%b expected grant=1000", g_rst);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({g_rst, v_rst, e_rst} !== 7'd0) begin
      failures++; $display("FAIL rst_async grant=%b valid=%b enc=%0d expected all zero", g_rst, v_rst, e_rst);
    end
    #2;
    rst_n = 1'b1;
    req_rst = 4'b1001;
    req_rr  = 4'b1001;
    tick();
    checks++;
    if ({g_rst, v_rst, e_rst} !== {4'b0001, 1'b1, 2'd0}) begin
      failures++; $display("FAIL rst_rearb grant=%b enc=%0d expected grant=0001 enc=0", g_rst, e_rst);
    end
    checks++;
    if ({g_rr, v_rr, e_rr} !== {4'b0001, 1'b1, 2'd0}) begin
      failures++; $display("FAIL rst_mask_clear grant=%b enc=%0d expected grant=0001 enc=0", g_rr, e_rr);
    end
    tick();
    checks++;
    if ({g_rst, e_rst} !== {4'b0001, 2'd0}) begin
      failures++; $display("FAIL rst_relock grant=%b expected grant=0001", g_rst);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_idle();
    test_block();
    test_block_ack();
    test_back_to_back();
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
